// File: rtl/rt_exec_monitor_if.sv
// rtl/rt_exec_monitor_if.sv - activation/status bundle between the harness and rt_exec_monitor
interface rt_exec_monitor_if #(
  parameter int NTASK = 2,
  parameter int CNT_W = 2
);
  logic [NTASK-1:0]       rt_act;
  logic [NTASK-1:0]       busy;
  logic [NTASK-1:0]       done;
  logic [NTASK*CNT_W-1:0] pend;
  logic                   excl_ok;
  logic                   overflow;

  modport master (
    output rt_act,
    input  busy, done, pend, excl_ok, overflow
  );

  modport slave (
    input  rt_act,
    output busy, done, pend, excl_ok, overflow
  );
endinterface

// File: rtl/rt_exec_monitor.sv
// rtl/rt_exec_monitor.sv - per-task real-time job queue/executor with exclusion and overflow flags
// Define RT_EXCL_ARB_EN to arbitrate starts so that at most one task runs at a time.
module rt_exec_monitor #(
  parameter int NTASK    = 2,
  parameter int EXEC_LEN = 2,
  parameter int QDEPTH   = 3,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  rt_exec_monitor_if.slave mon
);

  localparam int RUN_W = (EXEC_LEN > 1) ? $clog2(EXEC_LEN) : 1;
  localparam logic [RUN_W-1:0] RUN_LOAD = RUN_W'(EXEC_LEN - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(QDEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q [NTASK];
  state_t           state_d [NTASK];
  logic [RUN_W-1:0] cnt_q   [NTASK];
  logic [RUN_W-1:0] cnt_d   [NTASK];
  logic [CNT_W-1:0] pend_q  [NTASK];
  logic [CNT_W-1:0] pend_d  [NTASK];
  logic             excl_ok_q, excl_ok_d;
  logic             overflow_q, overflow_d;

  logic [NTASK-1:0] busy_v;
  logic [NTASK-1:0] done_v;
  logic [NTASK-1:0] eligible;
  logic [NTASK-1:0] start;
  logic [NTASK-1:0] start_q;
  logic [NTASK-1:0] start_a;
  logic [NTASK-1:0] queue_act;
  logic [NTASK-1:0] drop;
`ifdef RT_EXCL_ARB_EN
  logic             hold;
  logic             found;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTASK; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        pend_q[i]  <= '0;
      end
      excl_ok_q  <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NTASK; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pend_q[i]  <= pend_d[i];
      end
      excl_ok_q  <= excl_ok_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    busy_v    = '0;
    done_v    = '0;
    eligible  = '0;
    start     = '0;
    start_q   = '0;
    start_a   = '0;
    queue_act = '0;
    drop      = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
`ifdef RT_EXCL_ARB_EN
    hold      = 1'b0;
    found     = 1'b0;
`endif

    for (int i = 0; i < NTASK; i++) begin
      busy_v[i]   = (state_q[i] == RUN);
      done_v[i]   = (state_q[i] == RUN) && (cnt_q[i] == '0);
      eligible[i] = (pend_q[i] != '0) || mon.rt_act[i];
    end

`ifdef RT_EXCL_ARB_EN
    // A job still mid-execution blocks every start; at its last cycle the
    // lowest-index eligible task (possibly the same one) takes over seamlessly.
    for (int i = 0; i < NTASK; i++) begin
      if ((state_q[i] == RUN) && (cnt_q[i] != '0)) begin
        hold = 1'b1;
      end
    end
    for (int i = 0; i < NTASK; i++) begin
      if (!hold && !found && eligible[i]) begin
        start[i] = 1'b1;
        found    = 1'b1;
      end
    end
`else
    for (int i = 0; i < NTASK; i++) begin
      start[i] = eligible[i] && ((state_q[i] == IDLE) || (cnt_q[i] == '0));
    end
`endif

    for (int i = 0; i < NTASK; i++) begin
      // Queued work goes first; a same-cycle activation only starts directly
      // when nothing is waiting, otherwise it joins the queue.
      start_q[i]   = start[i] && (pend_q[i] != '0);
      start_a[i]   = start[i] && (pend_q[i] == '0);
      queue_act[i] = mon.rt_act[i] && !start_a[i];

      if (queue_act[i] && !start_q[i]) begin
        if (pend_q[i] == PEND_MAX) begin
          drop[i] = 1'b1;
        end else begin
          pend_d[i] = pend_q[i] + CNT_W'(1);
        end
      end else if (!queue_act[i] && start_q[i]) begin
        pend_d[i] = pend_q[i] - CNT_W'(1);
      end

      if (start[i]) begin
        state_d[i] = RUN;
        cnt_d[i]   = RUN_LOAD;
      end else if (state_q[i] == RUN) begin
        if (cnt_q[i] == '0) begin
          state_d[i] = IDLE;
        end else begin
          cnt_d[i] = cnt_q[i] - RUN_W'(1);
        end
      end
    end

    // Two or more set bits leave a nonzero value after clearing the lowest one.
    excl_ok_d  = excl_ok_q && ((busy_v & (busy_v - NTASK'(1))) == '0);
    overflow_d = overflow_q || (drop != '0);
  end

  always_comb begin
    mon.pend = '0;
    for (int i = 0; i < NTASK; i++) begin
      mon.pend[i*CNT_W +: CNT_W] = pend_q[i];
    end
  end

  assign mon.busy     = busy_v;
  assign mon.done     = done_v;
  assign mon.excl_ok  = excl_ok_q;
  assign mon.overflow = overflow_q;

endmodule

// File: tb/tb_rt_exec_monitor.sv
// tb/tb_rt_exec_monitor.sv - table-driven, scoreboarded bench for rt_exec_monitor
module tb_rt_exec_monitor;

  logic clk;
  logic rst;

  rt_exec_monitor_if #(.NTASK(2), .CNT_W(2)) mon_if ();

  rt_exec_monitor #(
    .NTASK(2),
    .EXEC_LEN(2),
    .QDEPTH(3),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] act;
    logic [1:0] busy;
    logic [1:0] done;
    logic [3:0] pend;
    logic       excl;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic ex_after_t4;

  task automatic add(input string nm, input logic r, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] d,
                     input logic [1:0] p0, input logic [1:0] p1,
                     input logic e, input logic o);
    vec_t v;
    v.name = nm; v.rst = r; v.act = a; v.busy = b; v.done = d;
    v.pend = {p1, p0}; v.excl = e; v.ovf = o;
    vecs.push_back(v);
  endtask

  task automatic chk(input string what, input int idx, input logic [3:0] act_v,
                     input logic [3:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", what, idx, act_v, exp_v);
    end
  endtask

  initial begin
    vec_t e;
    rst = 1'b0;
    mon_if.rt_act = 2'b00;

    // T1: reset then idle
    add("t1_rst", 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) add("t1_idle", 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);

    // T2: single activation, zero-wait start
    add("t2", 0, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0);
    add("t2", 0, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0);
    add("t2", 0, 2'b00, 2'b01, 2'b01, 0, 0, 1, 0);
    add("t2", 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
    add("t2", 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);

    // T6: activation on the retiring cycle restarts with no gap
    add("t6", 0, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0);
    add("t6", 0, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0);
    add("t6", 0, 2'b01, 2'b01, 2'b01, 0, 0, 1, 0);
    add("t6", 0, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0);
    add("t6", 0, 2'b00, 2'b01, 2'b01, 0, 0, 1, 0);
    add("t6", 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);

    // T3: continuous activations fill the queue, then overflow
    add("t3", 0, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0);
    add("t3", 0, 2'b01, 2'b01, 2'b00, 0, 0, 1, 0);
    add("t3", 0, 2'b01, 2'b01, 2'b01, 1, 0, 1, 0);
    add("t3", 0, 2'b01, 2'b01, 2'b00, 1, 0, 1, 0);
    add("t3", 0, 2'b01, 2'b01, 2'b01, 2, 0, 1, 0);
    add("t3", 0, 2'b01, 2'b01, 2'b00, 2, 0, 1, 0);
    add("t3", 0, 2'b01, 2'b01, 2'b01, 3, 0, 1, 0);
    add("t3", 0, 2'b01, 2'b01, 2'b00, 3, 0, 1, 0);
    add("t3", 0, 2'b00, 2'b01, 2'b01, 3, 0, 1, 1);
    add("t3", 0, 2'b00, 2'b01, 2'b00, 2, 0, 1, 1);
    add("t3", 0, 2'b00, 2'b01, 2'b01, 2, 0, 1, 1);
    add("t3", 0, 2'b00, 2'b01, 2'b00, 1, 0, 1, 1);
    add("t3", 0, 2'b00, 2'b01, 2'b01, 1, 0, 1, 1);
    add("t3", 0, 2'b00, 2'b01, 2'b00, 0, 0, 1, 1);
    add("t3", 0, 2'b00, 2'b01, 2'b01, 0, 0, 1, 1);
    add("t3", 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1);
    add("t3_rst", 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
    add("t3_idle", 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);

    // T4: both tasks activated together
`ifdef RT_EXCL_ARB_EN
    add("t4", 0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 0);
    add("t4", 0, 2'b00, 2'b01, 2'b00, 0, 1, 1, 0);
    add("t4", 0, 2'b00, 2'b01, 2'b01, 0, 1, 1, 0);
    add("t4", 0, 2'b00, 2'b10, 2'b00, 0, 0, 1, 0);
    add("t4", 0, 2'b00, 2'b10, 2'b10, 0, 0, 1, 0);
    add("t4", 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
    ex_after_t4 = 1'b1;
`else
    add("t4", 0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 0);
    add("t4", 0, 2'b00, 2'b11, 2'b00, 0, 0, 1, 0);
    add("t4", 0, 2'b00, 2'b11, 2'b11, 0, 0, 0, 0);
    add("t4", 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    add("t4", 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    ex_after_t4 = 1'b0;
`endif

    // T5: reset mid-job with task1 queue at 2 discards everything
    add("t5", 0, 2'b10, 2'b00, 2'b00, 0, 0, ex_after_t4, 0);
    add("t5", 0, 2'b10, 2'b10, 2'b00, 0, 0, ex_after_t4, 0);
    add("t5", 0, 2'b10, 2'b10, 2'b10, 0, 1, ex_after_t4, 0);
    add("t5", 0, 2'b10, 2'b10, 2'b00, 0, 1, ex_after_t4, 0);
    add("t5", 0, 2'b10, 2'b10, 2'b10, 0, 2, ex_after_t4, 0);
    add("t5", 0, 2'b00, 2'b10, 2'b00, 0, 2, ex_after_t4, 0);
    add("t5_rst", 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
    add("t5_post", 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
    add("t5_post", 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
    add("t5_post", 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      mon_if.rt_act = vecs[i].act;
      exp_q.push_back(vecs[i]);
      #1;
      e = exp_q.pop_front();
      chk({e.name, ".busy"}, i, {2'b00, mon_if.busy}, {2'b00, e.busy});
      chk({e.name, ".done"}, i, {2'b00, mon_if.done}, {2'b00, e.done});
      chk({e.name, ".pend"}, i, mon_if.pend, e.pend);
      chk({e.name, ".excl_ok"}, i, {3'b000, mon_if.excl_ok}, {3'b000, e.excl});
      chk({e.name, ".overflow"}, i, {3'b000, mon_if.overflow}, {3'b000, e.ovf});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
